// File: rtl/ad_tx_sample_fmt.sv
// ad_tx_sample_fmt: serialises per-channel I/Q sample words into clock-cycle
// slots for a CMOS DDR output stage (rising word = I, falling word = Q) and
// marks slot 0 with the TX frame bits. Missing samples are replaced by zeros
// so the frame cadence never breaks.
// Optional feature: define TX_UNDERFLOW_CNT_EN to add the saturating
// underflow_count output.
module ad_tx_sample_fmt #(
  parameter int DATA_WIDTH = 12,
  parameter int CHANNELS   = 1
) (
  input  logic                             clk,
  input  logic                             resetn,
  input  logic                             enable,
  input  logic [2*CHANNELS*DATA_WIDTH-1:0] s_data,
  input  logic                             s_valid,
  output logic                             s_ready,
  output logic [DATA_WIDTH-1:0]            tx_data_p,
  output logic [DATA_WIDTH-1:0]            tx_data_n,
  output logic                             tx_frame_p,
  output logic                             tx_frame_n,
  output logic                             underflow
`ifdef TX_UNDERFLOW_CNT_EN
  ,
  output logic [15:0]                      underflow_count
`endif
);

  localparam int SW = 2 * CHANNELS * DATA_WIDTH;
  // Base bit of channel 1 inside the holding register; collapses onto
  // channel 0 for a single-channel build so every select stays in range.
  localparam int HI = (CHANNELS == 2) ? 2 * DATA_WIDTH : 0;
  localparam logic LAST_SLOT = 1'(CHANNELS - 1);
  localparam logic TWO_CH    = (CHANNELS == 2);

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state, state_nxt;
  logic            slot, slot_nxt;
  logic            load;
  logic [SW-1:0]   hold;
  logic            emit_act;
  logic            emit_slot;
  logic            emit_uf;

  // Next-state, slot advance and slot-0 handshake decision
  always_comb begin
    state_nxt = state;
    slot_nxt  = slot;
    s_ready   = 1'b0;
    load      = 1'b0;
    case (state)
      IDLE: begin
        if (enable) begin
          state_nxt = RUN;
          slot_nxt  = 1'b0;
        end
      end
      RUN: begin
        s_ready  = (slot == 1'b0);
        load     = (slot == 1'b0);
        slot_nxt = (slot == LAST_SLOT) ? 1'b0 : slot + 1'b1;
        if ((slot == LAST_SLOT) && !enable) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FSM state and slot counter
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      slot  <= 1'b0;
    end else begin
      state <= state_nxt;
      slot  <= slot_nxt;
    end
  end

  // Capture stage: hold the sample (or zeros) and remember which slot to emit
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hold      <= '0;
      emit_act  <= 1'b0;
      emit_slot <= 1'b0;
      emit_uf   <= 1'b0;
    end else begin
      if (load) hold <= s_valid ? s_data : '0;
      emit_act  <= (state == RUN);
      emit_slot <= slot;
      emit_uf   <= load && !s_valid;
    end
  end

  // Output register: slot words, frame bits and the aligned underflow pulse.
  // The slot is emitted one cycle after its capture stage, so the final slot
  // of a sample still goes out after the FSM has returned to IDLE.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tx_data_p  <= '0;
      tx_data_n  <= '0;
      tx_frame_p <= 1'b0;
      tx_frame_n <= 1'b0;
      underflow  <= 1'b0;
    end else if (emit_act) begin
      tx_data_p  <= emit_slot ? hold[HI +: DATA_WIDTH] : hold[0 +: DATA_WIDTH];
      tx_data_n  <= emit_slot ? hold[HI+DATA_WIDTH +: DATA_WIDTH]
                              : hold[DATA_WIDTH +: DATA_WIDTH];
      tx_frame_p <= !emit_slot;
      tx_frame_n <= !emit_slot && TWO_CH;
      underflow  <= emit_uf;
    end else begin
      tx_data_p  <= '0;
      tx_data_n  <= '0;
      tx_frame_p <= 1'b0;
      tx_frame_n <= 1'b0;
      underflow  <= 1'b0;
    end
  end

`ifdef TX_UNDERFLOW_CNT_EN
  // Saturating count of inserted zero samples; cleared only by reset
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      underflow_count <= '0;
    end else if (underflow && (underflow_count != '1)) begin
      underflow_count <= underflow_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ad_tx_sample_fmt.sv
// Bench for ad_tx_sample_fmt: one single-channel and one dual-channel
// instance share stimulus; a queue-based sample model predicts every cycle.
module tb_ad_tx_sample_fmt;

  logic        clk = 1'b0;
  logic        resetn;
  logic        enable;
  logic        s_valid;
  logic [47:0] s_data;

  logic        rdy1, fp1, fn1, uf1;
  logic [11:0] p1, n1;
  logic        rdy2, fp2, fn2, uf2;
  logic [11:0] p2, n2;
`ifdef TX_UNDERFLOW_CNT_EN
  logic [15:0] cnt1, cnt2;
`endif

  always #5 clk = ~clk;

  ad_tx_sample_fmt #(.DATA_WIDTH(12), .CHANNELS(1)) u_dut1 (
    .clk(clk), .resetn(resetn), .enable(enable),
    .s_data(s_data[23:0]), .s_valid(s_valid), .s_ready(rdy1),
    .tx_data_p(p1), .tx_data_n(n1), .tx_frame_p(fp1), .tx_frame_n(fn1),
    .underflow(uf1)
`ifdef TX_UNDERFLOW_CNT_EN
    , .underflow_count(cnt1)
`endif
  );

  ad_tx_sample_fmt #(.DATA_WIDTH(12), .CHANNELS(2)) u_dut2 (
    .clk(clk), .resetn(resetn), .enable(enable),
    .s_data(s_data), .s_valid(s_valid), .s_ready(rdy2),
    .tx_data_p(p2), .tx_data_n(n2), .tx_frame_p(fp2), .tx_frame_n(fn2),
    .underflow(uf2)
`ifdef TX_UNDERFLOW_CNT_EN
    , .underflow_count(cnt2)
`endif
  );

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s actual=%h required=%h", nm, act, exp);
  endtask

  // ---------------- behavioural model ----------------
  // Each accepted (or missing) sample becomes CHANNELS output words queued
  // behind whatever is still being emitted; one word leaves per cycle.
  typedef struct packed {
    logic [11:0] p;
    logic [11:0] n;
    logic        fp;
    logic        fn;
    logic        uf;
  } ent_t;

  ent_t mq [2][$];
  ent_t cur [2];
  int   run [2];
  int   pos [2];
  int   mcnt [2];

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int k = 0; k < 2; k++) begin
        mq[k].delete();
        cur[k]  = '0;
        run[k]  = 0;
        pos[k]  = 0;
        mcnt[k] = 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        int   c;
        ent_t e;
        c = k + 1;
        if (mq[k].size() > 0) cur[k] = mq[k].pop_front();
        else cur[k] = '0;
        if (cur[k].uf && mcnt[k] < 65535) mcnt[k]++;
        if (run[k] != 0) begin
          if (pos[k] == 0) begin
            for (int ch = 0; ch < c; ch++) begin
              e.p  = s_valid ? s_data[ch*24 +: 12] : 12'h000;
              e.n  = s_valid ? s_data[ch*24+12 +: 12] : 12'h000;
              e.fp = (ch == 0);
              e.fn = (ch == 0) && (c == 2);
              e.uf = !s_valid && (ch == 0);
              mq[k].push_back(e);
            end
          end
          if (pos[k] == c - 1 && !enable) run[k] = 0;
          pos[k] = (pos[k] + 1) % c;
        end else if (enable) begin
          run[k] = 1;
          pos[k] = 0;
        end
      end
    end
  end

  // Per-cycle comparison of both instances against the model
  always @(negedge clk) begin
    chk("d1_ready", 32'(rdy1), 32'(run[0] != 0 && pos[0] == 0));
    chk("d1_p", 32'(p1), 32'(cur[0].p));
    chk("d1_n", 32'(n1), 32'(cur[0].n));
    chk("d1_frame", {30'd0, fp1, fn1}, {30'd0, cur[0].fp, cur[0].fn});
    chk("d1_uf", 32'(uf1), 32'(cur[0].uf));
    chk("d2_ready", 32'(rdy2), 32'(run[1] != 0 && pos[1] == 0));
    chk("d2_p", 32'(p2), 32'(cur[1].p));
    chk("d2_n", 32'(n2), 32'(cur[1].n));
    chk("d2_frame", {30'd0, fp2, fn2}, {30'd0, cur[1].fp, cur[1].fn});
    chk("d2_uf", 32'(uf2), 32'(cur[1].uf));
`ifdef TX_UNDERFLOW_CNT_EN
    chk("d1_cnt", 32'(cnt1), 32'(mcnt[0]));
    chk("d2_cnt", 32'(cnt2), 32'(mcnt[1]));
`endif
  end

  task automatic chk_idle(input string nm);
    chk({nm, "_out1"}, {p1, n1, fp1, fn1, uf1, rdy1}, 32'd0);
    chk({nm, "_out2"}, {p2, n2, fp2, fn2, uf2, rdy2}, 32'd0);
  endtask

  task automatic wait_rdy2();
    int n = 0;
    while (!rdy2 && n < 8) begin
      @(negedge clk);
      n++;
    end
    chk("wait_rdy2", 32'(rdy2), 32'd1);
  endtask

  // ---------------- stimulus with literal expectations ----------------
  initial begin
    for (int k = 0; k < 2; k++) begin
      cur[k] = '0; run[k] = 0; pos[k] = 0; mcnt[k] = 0;
    end
    resetn  = 1'b0;
    enable  = 1'b1;
    s_valid = 1'b1;
    s_data  = {12'hD44, 12'hC33, 12'hB22, 12'hA11};
    repeat (3) @(negedge clk);
    chk_idle("reset");
    resetn = 1'b1;

    @(negedge clk);
    chk("start_rdy1", 32'(rdy1), 32'd1);
    chk("start_rdy2", 32'(rdy2), 32'd1);
    @(negedge clk);
    chk("slot1_rdy2", 32'(rdy2), 32'd0);
    @(negedge clk);
    chk("c2_s0", {p2, n2, fp2, fn2, uf2}, {12'hA11, 12'hB22, 1'b1, 1'b1, 1'b0});
    chk("c1_s0", {p1, n1, fp1, fn1, uf1}, {12'hA11, 12'hB22, 1'b1, 1'b0, 1'b0});
    @(negedge clk);
    chk("c2_s1", {p2, n2, fp2, fn2, uf2}, {12'hC33, 12'hD44, 1'b0, 1'b0, 1'b0});

    s_data = {24'h000000, 12'h123, 12'h456};
    repeat (2) @(negedge clk);
    chk("c1_stream_a", {p1, n1, fp1, fn1, uf1}, {12'h456, 12'h123, 1'b1, 1'b0, 1'b0});
    @(negedge clk);
    chk("c1_stream_b", {p1, n1, fp1, fn1, uf1}, {12'h456, 12'h123, 1'b1, 1'b0, 1'b0});

    // single missing sample at a dual-channel slot 0
    wait_rdy2();
    s_valid = 1'b0;
    @(negedge clk);
    s_valid = 1'b1;
    @(negedge clk);
    chk("uf_s0", {p2, n2, fp2, fn2, uf2}, {12'h000, 12'h000, 1'b1, 1'b1, 1'b1});
    @(negedge clk);
    chk("uf_s1", {p2, n2, fp2, fn2, uf2}, {12'h000, 12'h000, 1'b0, 1'b0, 1'b0});
`ifdef TX_UNDERFLOW_CNT_EN
    chk("uf_count", 32'(cnt2), 32'd1);
`endif

    // stop in the slot-0 accept cycle
    s_data = {12'hD44, 12'hC33, 12'hB22, 12'hA11};
    wait_rdy2();
    enable = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("stop_s0", {p2, n2, fp2, fn2}, {12'hA11, 12'hB22, 1'b1, 1'b1});
    @(negedge clk);
    chk("stop_s1", {p2, n2, fp2, fn2, rdy2}, {12'hC33, 12'hD44, 1'b0, 1'b0, 1'b0});
    @(negedge clk);
    chk_idle("stop_idle");
    repeat (3) begin
      @(negedge clk);
      chk("stop_rdy2", 32'(rdy2), 32'd0);
    end

    // randomized traffic with occasional asynchronous reset pulses
    enable = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 19) == 0) enable = !enable;
      s_valid = ($urandom_range(0, 9) < 7);
      s_data[31:0]  = $urandom();
      s_data[47:32] = 16'($urandom());
      if ($urandom_range(0, 199) == 0) begin
        #2 resetn = 1'b0;
        #1 chk_idle("async_rst");
        @(negedge clk);
        resetn = 1'b1;
      end
    end

`ifdef TX_UNDERFLOW_CNT_EN
    enable  = 1'b1;
    s_valid = 1'b0;
    repeat (70000) @(negedge clk);
    chk("sat_count", 32'(cnt1), 32'h0000FFFF);
`endif

    @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/ad_tx_sample_fmt.md
# ad_tx_sample_fmt

Transmit-side sample formatter feeding the CMOS DDR output stage of the RF transceiver data port. Accepts parallel I/Q sample words per channel over a valid/ready stream, serialises channels into clock-cycle slots, and produces the per-edge data words (rising/falling) plus the TX frame marker that the ODDR output stage drives onto the pins. Underflow is absorbed by inserting zero samples so that the frame cadence never breaks.

## Interface
- DATA_WIDTH, 12, bits per I or Q component (one DDR edge word)
- CHANNELS, 1, TX channels interleaved on the port; legal values 1 or 2
- clk  input  1  data-port clock; same clock the DDR output stage uses
- resetn  input  1  asynchronous, active-low reset
- enable  input  1  level; 1 = stream samples to the port, 0 = idle
- s_data  input  2*CHANNELS*DATA_WIDTH  packed sample {..., Q1, I1, Q0, I0}, I0 in LSBs
- s_valid  input  1  s_data holds a sample
- s_ready  output  1  block accepts s_data this cycle
- tx_data_p  output  DATA_WIDTH  word for rising edge (ODDR D1)
- tx_data_n  output  DATA_WIDTH  word for falling edge (ODDR D2)
- tx_frame_p  output  1  frame bit for rising edge
- tx_frame_n  output  1  frame bit for falling edge
- underflow  output  1  one-cycle pulse: zero sample inserted
- underflow_count  output  16  saturating underflow count (only with macro, see Configuration)

## Operation
- Clock and reset: one clock domain; resetn asserts asynchronously, deasserts synchronously to clk (external synchroniser).
- FSM states: IDLE, RUN.
  - IDLE -> RUN on the first clk edge with enable=1; slot counter = 0.
  - RUN -> IDLE only at the end of the last slot (slot = CHANNELS-1) with enable=0; an in-progress sample is always finished.
- Slot counter: 0..CHANNELS-1, wraps to 0 after CHANNELS-1; advances every cycle in RUN.
- s_ready = 1 only in RUN with slot = 0; 0 in IDLE and in slot 1.
- Slot 0 in RUN: if s_valid, capture s_data into holding register; else load all zeros and pulse underflow.
- Output register per cycle (slot k of the current sample): tx_data_p = I_k, tx_data_n = Q_k.
- Frame: slot 0 -> tx_frame_p = 1; tx_frame_n = 1 when CHANNELS=2, 0 when CHANNELS=1. Slot 1 -> both 0.
- IDLE: tx_data_p, tx_data_n, tx_frame_p, tx_frame_n all 0; s_ready 0; no underflow pulses.
- Words are passed unmodified (two's complement, no rescaling); width fixed at DATA_WIDTH.

## Timing
- Reset values: s_ready 0, tx_data_p 0, tx_data_n 0, tx_frame_p 0, tx_frame_n 0, underflow 0, underflow_count 0, FSM IDLE, slot 0.
- Latency: handshake (or underflow decision) at edge t -> slot-0 words and frame on outputs after edge t+1; slot-1 words after edge t+2.
- underflow pulse is registered, aligned with the zero words it marks.
- enable 0->1: RUN after next edge; s_ready high the cycle after.
- enable 1->0 mid-sample (CHANNELS=2, slot 0): slot 1 still emitted, then IDLE; s_ready is not raised again.
- Simultaneous enable=0 and s_valid in slot 0 while in RUN: the sample is accepted and emitted in full.
- resetn mid-sample: outputs zero immediately (asynchronous); the partially emitted sample is dropped.
- Throughput: one sample per CHANNELS cycles; s_valid held with s_ready=0 has no effect.

## Configuration
- TX_UNDERFLOW_CNT_EN defined: underflow_count port exists; increments by 1 on each underflow pulse, saturates at 16'hFFFF, cleared only by resetn.
- TX_UNDERFLOW_CNT_EN undefined: underflow_count port and counter logic are absent; underflow pulse unchanged.

## Test plan
- Reset: hold resetn=0 with enable=1, s_valid=1 -> all outputs 0, s_ready 0; release -> RUN after one edge, s_ready=1 the next cycle.
- CHANNELS=1 stream: s_data = {Q0=12'h123, I0=12'h456} each cycle, s_valid=1 -> one cycle later tx_data_p=12'h456, tx_data_n=12'h123, tx_frame_p=1, tx_frame_n=0, every cycle, no underflow.
- CHANNELS=2 stream: s_data={12'hD44,12'hC33,12'hB22,12'hA11} -> outputs (A11/B22, frame 1/1) then (C33/D44, frame 0/0); s_ready alternates 1,0.
- Underflow: CHANNELS=2, drop s_valid for one slot-0 -> two cycles of zero words with frame 1/1 then 0/0, underflow one cycle; with TX_UNDERFLOW_CNT_EN underflow_count = 1.
- Stop mid-sample: CHANNELS=2, deassert enable in the slot-0 accept cycle -> slot 0 and slot 1 emitted, then all outputs 0, s_ready stays 0.
- Saturation (macro on): force 70000 underflows -> underflow_count holds 16'hFFFF.
